// File: rtl/fft_pkg.sv
// Shared widths and twiddle generation for the R2SDF stage. FFT_STAGE_SCALE_EN removes per-stage growth.
// Complex values travel as a cplx_t {r, i} struct that each module declares at its own width.
package fft_pkg;

    function automatic int fft_dw(input int data_width, input int series);
        return data_width + 8 + series;
    endfunction

    function automatic int fft_ow(input int data_width, input int series);
`ifdef FFT_STAGE_SCALE_EN
        return fft_dw(data_width, series);
`else
        return fft_dw(data_width, series) + 1;
`endif
    endfunction

    // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), 1.0 scaled to 2^(tw_width-2)
    function automatic int tw_cos(input int k, input int pow, input int tw_width);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << pow);
        return int'($cos(ang) * real'(1 << (tw_width - 2)));
    endfunction

    function automatic int tw_nsin(input int k, input int pow, input int tw_width);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << pow);
        return int'(-$sin(ang) * real'(1 << (tw_width - 2)));
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle lookup for k = 0 .. N/2-1; purely combinational, zero latency, no flow control.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int POW      = 3,
    parameter int TW_WIDTH = 16
) (
    input  logic [POW-2:0]              k,
    output logic signed [TW_WIDTH-1:0]  wr,
    output logic signed [TW_WIDTH-1:0]  wi
);
    localparam int NH = 1 << (POW - 1);

    logic signed [TW_WIDTH-1:0] tab_r [NH];
    logic signed [TW_WIDTH-1:0] tab_i [NH];

    for (genvar g = 0; g < NH; g++) begin : g_tab
        localparam int RE = tw_cos(g, POW, TW_WIDTH);
        localparam int IM = tw_nsin(g, POW, TW_WIDTH);
        assign tab_r[g] = RE[TW_WIDTH-1:0];
        assign tab_i[g] = IM[TW_WIDTH-1:0];
    end

    assign wr = tab_r[k];
    assign wi = tab_i[k];
endmodule

// File: rtl/fft_r2sdf_stage.sv
// Radix-2 DIF single-path delay-feedback stage; each output is registered 1 cycle after its input beat.
// No backpressure: the stage advances only on sink_valid. FFT_STAGE_SCALE_EN halves sums and rotated differences.
module fft_r2sdf_stage
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SERIES     = 0,
    parameter int POW        = 3,
    parameter int TW_WIDTH   = 16,
    localparam int DW = fft_dw(DATA_WIDTH, SERIES),
    localparam int OW = fft_ow(DATA_WIDTH, SERIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sink_valid,
    input  logic                 sink_sop,
    input  logic signed [DW-1:0] sink_r,
    input  logic signed [DW-1:0] sink_i,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    output logic signed [OW-1:0] source_r,
    output logic signed [OW-1:0] source_i
);
    localparam int SW  = DW + 1;
    localparam int PW  = SW + TW_WIDTH;
    localparam int L   = 1 << (POW - SERIES - 1);
    localparam int JW  = POW - SERIES;
    localparam int RND = 1 << (TW_WIDTH - 3);

    typedef struct packed {
        logic signed [OW-1:0] r;
        logic signed [OW-1:0] i;
    } cplx_t;

    // One real product, rounded half-up and saturated back to the full-growth width
    function automatic logic signed [SW-1:0] rmul(input logic signed [SW-1:0] a,
                                                  input logic signed [TW_WIDTH-1:0] b);
        logic signed [PW-1:0] p;
        p = (PW'(a) * PW'(b) + PW'(RND)) >>> (TW_WIDTH - 2);
        if ((&p[PW-1:SW-1]) || !(|p[PW-1:SW-1]))
            return p[SW-1:0];
        return p[PW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    endfunction

    function automatic logic signed [OW-1:0] fin(input logic signed [SW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        logic signed [SW:0] t;
        t = (SW+1)'(v) + (SW+1)'(1);
        return OW'(t >>> 1);
`else
        return v;
`endif
    endfunction

    logic [POW-1:0]          cnt;
    logic                    primed;
    cplx_t                   dly [L];
    cplx_t                   head;
    cplx_t                   wr_val;
    logic                    resync;
    logic                    primed_eff;
    logic [POW-1:0]          ce;
    logic [JW-1:0]           jloc;
    logic                    bfly;
    logic [POW-2:0]          kidx;
    logic signed [TW_WIDTH-1:0] tw_r, tw_i;
    logic signed [SW-1:0]    sum_r, sum_i, dif_r, dif_i, rot_r, rot_i;
    logic signed [OW-1:0]    out_r, out_i;

    // A mid-frame sop makes this beat index 0 of a fresh frame
    assign resync     = sink_sop && (cnt != '0);
    assign primed_eff = primed && !resync;
    assign ce         = resync ? '0 : cnt;
    assign jloc       = ce[JW-1:0];
    assign bfly       = jloc[JW-1];
    assign kidx       = (POW-1)'(jloc & ~JW'(L)) << SERIES;
    assign head       = dly[L-1];

    fft_twiddle_rom #(
        .POW      (POW),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .k  (kidx),
        .wr (tw_r),
        .wi (tw_i)
    );

    assign sum_r = SW'(head.r) + SW'(sink_r);
    assign sum_i = SW'(head.i) + SW'(sink_i);
    assign dif_r = SW'(head.r) - SW'(sink_r);
    assign dif_i = SW'(head.i) - SW'(sink_i);
    assign rot_r = rmul(dif_r, tw_r) - rmul(dif_i, tw_i);
    assign rot_i = rmul(dif_r, tw_i) + rmul(dif_i, tw_r);

    assign wr_val.r = bfly ? fin(rot_r) : OW'(sink_r);
    assign wr_val.i = bfly ? fin(rot_i) : OW'(sink_i);
    assign out_r    = bfly ? fin(sum_r) : head.r;
    assign out_i    = bfly ? fin(sum_i) : head.i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            primed       <= 1'b0;
            for (int i = 0; i < L; i++) dly[i] <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_r     <= '0;
            source_i     <= '0;
        end else begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            if (sink_valid) begin
                cnt    <= ce + 1'b1;
                primed <= !resync && (primed || (bfly && (&jloc)));
                dly[0] <= wr_val;
                for (int i = 1; i < L; i++) dly[i] <= resync ? '0 : dly[i-1];
                source_valid <= bfly || primed_eff;
                source_sop   <= (ce == POW'(L));
                source_eop   <= primed_eff && (ce == POW'(L - 1));
                source_r     <= out_r;
                source_i     <= out_i;
            end
        end
    end
endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Bench for fft_r2sdf_stage (POW=3, SERIES=0): directed frame table, random frames against a frame-level model.
module tb_fft_r2sdf_stage;
    localparam int DW = 24;
`ifdef FFT_STAGE_SCALE_EN
    localparam int OW = 24;
`else
    localparam int OW = 25;
`endif
    localparam int N  = 8;
    localparam int L  = 4;
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sink_valid = 1'b0;
    logic sink_sop = 1'b0;
    logic signed [DW-1:0] sink_r = '0;
    logic signed [DW-1:0] sink_i = '0;
    logic source_valid, source_sop, source_eop;
    logic signed [OW-1:0] source_r, source_i;

    int n_chk = 0;
    int n_fail = 0;
    string phase = "init";

    fft_r2sdf_stage #(
        .DATA_WIDTH (16),
        .SERIES     (0),
        .POW        (3),
        .TW_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_r       (sink_r),
        .sink_i       (sink_i),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_r     (source_r),
        .source_i     (source_i)
    );

    always #5 clk = ~clk;

    // Frame: impulse (vr + j*vi) at pos, or constant if pos < 0.
    // Expected sums / differences: value at given index (everywhere if < 0), zero elsewhere.
    typedef struct packed {
        int pos; int vr; int vi;
        int s_pos; int sr; int si;
        int d_pos; int dr; int di;
    } vec_t;
    vec_t tv [NV];

    int twr [4] = '{16384, 11585, 0, -11585};
    int twi [4] = '{0, -11585, -16384, -11585};

    int     m_pos;
    bit     m_have;
    longint m_xr [N];
    longint m_xi [N];
    longint m_dr [L];
    longint m_di [L];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, name, act, exp);
        end
    endtask

    function automatic longint scl(input longint v);
`ifdef FFT_STAGE_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic longint rmul(input longint a, input longint b);
        return (a * b + 8192) >>> 14;
    endfunction

    task automatic beat(input longint xr, input longint xi, input logic sop,
                        input logic ev, input longint er, input longint ei,
                        input logic es, input logic ee, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            sink_valid = 1'b0;
            sink_sop   = 1'b0;
            @(posedge clk); #1;
            chk("gap_valid", longint'(source_valid), 0);
        end
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_r     = DW'(xr);
        sink_i     = DW'(xi);
        @(posedge clk); #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        chk("valid", longint'(source_valid), longint'(ev));
        if (ev) begin
            chk("re", longint'(source_r), er);
            chk("im", longint'(source_i), ei);
            chk("sop", longint'(source_sop), longint'(es));
            chk("eop", longint'(source_eop), longint'(ee));
        end
    endtask

    // Frame-level DIF model: sums leave in the second half, differences one frame-half later
    task automatic model_beat(input longint xr, input longint xi, input logic sop, input int gaps);
        logic ev, es, ee;
        longint er, ei, ar, ai;
        int n;
        ev = 0; es = 0; ee = 0; er = 0; ei = 0;
        if (sop && m_pos != 0) begin
            m_pos  = 0;
            m_have = 0;
        end
        if (m_pos < L) begin
            if (m_have) begin
                ev = 1; er = m_dr[m_pos]; ei = m_di[m_pos]; ee = (m_pos == L - 1);
            end
            m_xr[m_pos] = xr;
            m_xi[m_pos] = xi;
        end else begin
            n  = m_pos - L;
            ev = 1; es = (n == 0);
            er = scl(m_xr[n] + xr);
            ei = scl(m_xi[n] + xi);
            ar = m_xr[n] - xr;
            ai = m_xi[n] - xi;
            m_dr[n] = scl(rmul(ar, twr[n]) - rmul(ai, twi[n]));
            m_di[n] = scl(rmul(ar, twi[n]) + rmul(ai, twr[n]));
            if (m_pos == N - 1) m_have = 1;
        end
        m_pos = (m_pos + 1) % N;
        beat(xr, xi, sop, ev, er, ei, es, ee, gaps);
    endtask

    task automatic do_reset();
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", longint'(source_valid), 0);
        chk("rst_sop", longint'(source_sop), 0);
        chk("rst_eop", longint'(source_eop), 0);
        chk("rst_re", longint'(source_r), 0);
        chk("rst_im", longint'(source_i), 0);
        rst_n  = 1'b1;
        m_pos  = 0;
        m_have = 0;
    endtask

    function automatic longint rnd_val();
        return longint'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    initial begin
        longint xr, xi, er, ei;
        logic ev;
        int n;

        tv[0] = '{0, 1000, 0,     0, 1000, 0,    0, 1000, 0};
        tv[1] = '{-1, 1000, 0,   -1, 2000, 0,    0, 0, 0};
        tv[2] = '{1, 1000, 0,     1, 1000, 0,    1, 707, -707};
        tv[3] = '{4, 1000, 0,     0, 1000, 0,    0, -1000, 0};
        tv[4] = '{2, 0, 500,      2, 0, 500,     2, 500, 0};
        tv[5] = '{3, 1000, 0,     3, 1000, 0,    3, -707, -707};
        tv[6] = '{7, -300, 200,   3, -300, 200,  3, -353, -71};

        for (int pass = 0; pass < 2; pass++) begin
            phase = (pass == 0) ? "tbl" : "tbl_gap";
            do_reset();
            for (int f = 0; f <= NV; f++) begin
                for (int b = 0; b < N; b++) begin
                    xr = 0; xi = 0;
                    if (f < NV && (tv[f].pos < 0 || tv[f].pos == b)) begin
                        xr = tv[f].vr; xi = tv[f].vi;
                    end
                    er = 0; ei = 0;
                    if (b < L) begin
                        ev = (f > 0);
                        if (f > 0 && (tv[f-1].d_pos < 0 || tv[f-1].d_pos == b)) begin
                            er = scl(tv[f-1].dr); ei = scl(tv[f-1].di);
                        end
                    end else begin
                        ev = 1'b1;
                        n  = b - L;
                        if (f < NV && (tv[f].s_pos < 0 || tv[f].s_pos == n)) begin
                            er = scl(tv[f].sr); ei = scl(tv[f].si);
                        end
                    end
                    beat(xr, xi, (b == 0), ev, er, ei, (b == L), (b == L - 1 && f > 0),
                         pass == 0 ? 0 : int'($urandom_range(0, 1)));
                end
            end
        end

        phase = "rnd";
        do_reset();
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < N; b++)
                model_beat(rnd_val(), rnd_val(), (b == 0 && f != 2), int'($urandom_range(0, 1)));

        phase = "mid_rst";
        for (int b = 0; b < 3; b++) model_beat(rnd_val(), rnd_val(), (b == 0), 0);
        rst_n = 1'b0;
        #2;
        chk("arst_valid", longint'(source_valid), 0);
        chk("arst_re", longint'(source_r), 0);
        chk("arst_im", longint'(source_i), 0);
        rst_n  = 1'b1;
        m_pos  = 0;
        m_have = 0;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < N; b++)
                model_beat(rnd_val(), rnd_val(), 1'b0, int'($urandom_range(0, 1)));
        for (int b = 0; b < N; b++) model_beat(0, 0, (b == 0), 0);

        phase = "resync";
        do_reset();
        for (int b = 0; b < 5; b++) model_beat(rnd_val(), rnd_val(), (b == 0), 0);
        model_beat(rnd_val(), rnd_val(), 1'b1, 0);
        for (int b = 1; b < N; b++) model_beat(rnd_val(), rnd_val(), 1'b0, int'($urandom_range(0, 1)));
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < N; b++)
                model_beat(rnd_val(), rnd_val(), (b == 0), int'($urandom_range(0, 1)));
        for (int b = 0; b < N; b++) model_beat(0, 0, (b == 0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
